// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Owns the PC, drives the instruction-memory address, and captures fetched
// words into IF/ID. A hazard stall freezes everything; a decode-stage
// branch/jump redirects the PC and squashes the wrong-path word.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        branch_taken_ID,
  input  logic [31:0] branch_target_ID,
  input  logic        jump_ID,
  input  logic [31:0] jump_target_ID,
  output logic [31:0] instr_ID,
  output logic [31:0] pcplus4_ID,
  output logic        valid_ID,
  output logic [31:0] fetch_count
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic        valid;
  } ifid_t;

  // All-zero encoding is sll $0,$0,0: writes r0, so it never triggers a stall.
  localparam ifid_t BUBBLE = '{instr: 32'h0, pcplus4: 32'h0, valid: 1'b0};

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        redirect;
  ifid_t       ifid;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // A bubble in IF/ID cannot redirect; a stalled decode has stale operands.
  assign redirect = (jump_ID | branch_taken_ID) & ifid.valid & ~stall;
  assign target   = jump_ID ? {jump_target_ID[31:2], 2'b00}
                            : {branch_target_ID[31:2], 2'b00};

  // PC, IF/ID and fetch counter update: stall > redirect > imem wait > fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= {RESET_PC[31:2], 2'b00};
      ifid        <= BUBBLE;
      fetch_count <= 32'h0;
    end else if (stall) begin
      pc          <= pc;
      ifid        <= ifid;
      fetch_count <= fetch_count;
    end else if (redirect) begin
      pc          <= target;
      ifid        <= BUBBLE;
    end else if (!imem_ready) begin
      ifid        <= BUBBLE;
    end else begin
      pc          <= pc_plus4;
      ifid        <= '{instr: imem_rdata, pcplus4: pc_plus4, valid: 1'b1};
      fetch_count <= fetch_count + 32'd1;
    end
  end

  assign instr_ID   = ifid.instr;
  assign pcplus4_ID = ifid.pcplus4;
  assign valid_ID   = ifid.valid;

endmodule
